// File: rtl/eth_reset_sequencer_pkg.sv
// Shared types for the Ethernet reset sequencer: FSM state encoding and the
// registered reset-output bundle.
package eth_reset_sequencer_pkg;

    typedef enum logic [2:0] {
        StWaitLock = 3'd0,
        StPhyRst   = 3'd1,
        StSettle   = 3'd2,
        StTxRel    = 3'd3,
        StRxRel    = 3'd4,
        StReady    = 3'd5
    } state_e;

    typedef struct packed {
        logic phy_reset_n;
        logic tx_rst;
        logic rx_rst;
        logic ready;
    } rst_out_t;

    localparam rst_out_t RstOutAsserted = 4'b0110;

    function automatic rst_out_t state_outputs(state_e st);
        rst_out_t o;
        o = RstOutAsserted;
        unique case (st)
            StSettle: o = 4'b1110;
            StTxRel:  o = 4'b1010;
            StRxRel:  o = 4'b1000;
            StReady:  o = 4'b1001;
            default:  o = RstOutAsserted;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/eth_sync2.sv
// Two-flop synchronizer with synchronous active-high reset.
module eth_sync2 #(
    parameter int unsigned width_p = 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] d_i,
    output logic [width_p-1:0] q_o
);

    logic [width_p-1:0] meta_q;
    logic [width_p-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/eth_reset_sequencer.sv
// Power-up / restart sequencer: waits for PLL lock, pulses the PHY reset, lets the PHY
// settle, then releases MAC TX and RX resets in turn before flagging ready.
module eth_reset_sequencer
    import eth_reset_sequencer_pkg::*;
#(
    parameter int phy_rst_cycles_p    = 1000,
    parameter int phy_settle_cycles_p = 5000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       pll_locked_i,
    input  logic       sw_reset_i,
    output logic       phy_reset_n_o,
    output logic       mac_tx_reset_o,
    output logic       mac_rx_reset_o,
    output logic       ready_o,
    output logic [2:0] state_o
);

    localparam int MaxCycles = (phy_rst_cycles_p > phy_settle_cycles_p) ?
                               phy_rst_cycles_p : phy_settle_cycles_p;
    localparam int CntW = $clog2(MaxCycles + 1);

    localparam logic [CntW-1:0] RstLast    = CntW'(phy_rst_cycles_p - 1);
    localparam logic [CntW-1:0] SettleLast = CntW'(phy_settle_cycles_p - 1);

    if (phy_rst_cycles_p < 1 || phy_settle_cycles_p < 1) begin : gen_param_check
        $error("eth_reset_sequencer: cycle parameters must be at least 1");
    end

    logic            lock_s;
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    rst_out_t        out_q;

    eth_sync2 #(
        .width_p (1)
    ) u_lock_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d_i     (pll_locked_i),
        .q_o     (lock_s)
    );

    // Loss of lock dominates; a software request (or fresh lock) re-arms PHY_RST.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!lock_s) begin
            state_d = StWaitLock;
            cnt_d   = '0;
        end else if (sw_reset_i || state_q == StWaitLock) begin
            state_d = StPhyRst;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StPhyRst: begin
                    if (cnt_q == RstLast) begin
                        state_d = StSettle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StSettle: begin
                    if (cnt_q == SettleLast) begin
                        state_d = StTxRel;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StTxRel: state_d = StRxRel;
                StRxRel: state_d = StReady;
                StReady: state_d = StReady;
                default: begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they flip on the same edge as state_q.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StWaitLock;
            cnt_q   <= '0;
            out_q   <= RstOutAsserted;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= state_outputs(state_d);
        end
    end

    assign phy_reset_n_o  = out_q.phy_reset_n;
    assign mac_tx_reset_o = out_q.tx_rst;
    assign mac_rx_reset_o = out_q.rx_rst;
    assign ready_o        = out_q.ready;
    assign state_o        = state_q;

endmodule

// File: tb/tb_eth_reset_sequencer.sv
// Self-checking bench for eth_reset_sequencer: timestamp-based reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_eth_reset_sequencer;
    import eth_reset_sequencer_pkg::*;

    localparam int RstCycles    = 4;
    localparam int SettleCycles = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       pll;
    logic       sw;
    logic       phy_n;
    logic       tx_rst;
    logic       rx_rst;
    logic       ready;
    logic [2:0] state;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    eth_reset_sequencer #(
        .phy_rst_cycles_p    (RstCycles),
        .phy_settle_cycles_p (SettleCycles)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .pll_locked_i   (pll),
        .sw_reset_i     (sw),
        .phy_reset_n_o  (phy_n),
        .mac_tx_reset_o (tx_rst),
        .mac_rx_reset_o (rx_rst),
        .ready_o        (ready),
        .state_o        (state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: the sequence is described by when it last (re)started.
    int   cyc = 0;
    int   t0 = 0;
    bit   waiting = 1'b1;
    bit   model_valid = 1'b0;
    logic m_meta = 1'b0;
    logic m_lock = 1'b0;

    always @(posedge clk) begin
        logic ls;
        ls = m_lock;
        cyc++;
        if (reset) begin
            m_meta      = 1'b0;
            m_lock      = 1'b0;
            waiting     = 1'b1;
            model_valid = 1'b1;
        end else begin
            m_lock = m_meta;
            m_meta = pll;
            if (!ls) begin
                waiting = 1'b1;
            end else if (waiting || sw) begin
                waiting = 1'b0;
                t0      = cyc;
            end
        end
    end

    function automatic logic [6:0] model_expect();
        state_e     st;
        logic [3:0] o;
        int         el;
        if (waiting) begin
            st = StWaitLock;
        end else begin
            el = cyc - t0;
            if (el < RstCycles)                         st = StPhyRst;
            else if (el < RstCycles + SettleCycles)     st = StSettle;
            else if (el == RstCycles + SettleCycles)    st = StTxRel;
            else if (el == RstCycles + SettleCycles + 1) st = StRxRel;
            else                                        st = StReady;
        end
        case (st)
            StSettle: o = 4'b1110;
            StTxRel:  o = 4'b1010;
            StRxRel:  o = 4'b1000;
            StReady:  o = 4'b1001;
            default:  o = 4'b0110;
        endcase
        return {st, o};
    endfunction

    function automatic logic [6:0] obs();
        return {state, phy_n, tx_rst, rx_rst, ready};
    endfunction

    always @(negedge clk) begin
        if (model_valid) check("model", 32'(obs()), 32'(model_expect()));
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [6:0] tr [0:15];
    int         low_cnt;
    bit         hit;

    initial begin
        reset = 1'b1;
        pll   = 1'b1;
        sw    = 1'b0;
        repeat (3) step();
        check("reset_outputs", 32'(obs()), 32'({StWaitLock, 4'b0110}));

        // Power-up with lock already present.
        reset = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            step();
            tr[k] = obs();
        end
        check("s1_still_waiting", 32'(tr[2][6:4]), 32'(StWaitLock));
        check("s1_phy_rst_entry", 32'(tr[3][6:4]), 32'(StPhyRst));
        check("s1_phy_low_first", 32'(tr[3][3]), 32'd0);
        check("s1_phy_low_last", 32'(tr[6][3]), 32'd0);
        check("s1_phy_rise", 32'(tr[7][3]), 32'd1);
        check("s1_tx_still_rst", 32'(tr[9][2]), 32'd1);
        check("s1_tx_fall", 32'(tr[10][2]), 32'd0);
        check("s1_rx_still_rst", 32'(tr[10][1]), 32'd1);
        check("s1_rx_fall", 32'(tr[11][1]), 32'd0);
        check("s1_ready_low", 32'(tr[11][0]), 32'd0);
        check("s1_ready_rise", 32'(tr[12][0]), 32'd1);
        check("s1_ready_state", 32'(tr[12][6:4]), 32'(StReady));

        // One-cycle software restart from READY replays the full sequence.
        sw = 1'b1;
        step();
        tr[1] = obs();
        sw = 1'b0;
        for (int k = 2; k <= 12; k++) begin
            step();
            tr[k] = obs();
        end
        check("sw_pulse_restart", 32'(tr[1]), 32'({StPhyRst, 4'b0110}));
        check("sw_pulse_phy_low", 32'(tr[4][3]), 32'd0);
        check("sw_pulse_phy_rise", 32'(tr[5][3]), 32'd1);
        check("sw_pulse_ready_low", 32'(tr[9][0]), 32'd0);
        check("sw_pulse_ready_rise", 32'(tr[10][0]), 32'd1);

        // Held software restart keeps PHY_RST re-armed.
        low_cnt = 0;
        sw = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            if (!phy_n) low_cnt++;
        end
        sw = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (phy_n) break;
            low_cnt++;
        end
        check("sw_held_low_cycles", 32'(low_cnt), 32'd10);

        // Lock lost two cycles into SETTLE.
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (state == StReady) begin
                hit = 1'b1;
                break;
            end
        end
        check("reach_ready", 32'(hit), 32'd1);
        sw = 1'b1;
        step();
        sw = 1'b0;
        repeat (5) step();
        check("settle_second_cycle", 32'(state), 32'(StSettle));
        pll = 1'b0;
        repeat (3) step();
        check("lock_loss", 32'(obs()), 32'({StWaitLock, 4'b0110}));
        pll = 1'b1;

        // Reset pulse during TX_REL.
        hit = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (state == StTxRel) begin
                hit = 1'b1;
                break;
            end
        end
        check("reach_tx_rel", 32'(hit), 32'd1);
        reset = 1'b1;
        step();
        check("reset_in_tx_rel", 32'(obs()), 32'({StWaitLock, 4'b0110}));
        reset = 1'b0;

        // No lock at all.
        pll   = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            check("no_lock_idle", 32'({state, ready}), 32'({StWaitLock, 1'b0}));
        end

        // Randomized lock, restart and reset activity.
        pll = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 59) == 0) pll = ~pll;
            if ($urandom_range(0, 29) == 0) sw = 1'b1;
            else if ($urandom_range(0, 2) == 0) sw = 1'b0;
        end
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/eth_reset_sequencer.md
ETH_RESET_SEQUENCER -- requirements
Module: eth_reset_sequencer

Interface
REQ-001 SHALL have parameter phy_rst_cycles_p, default 1000, cycles phy_reset_n_o is held low per reset pulse.
REQ-002 SHALL have parameter phy_settle_cycles_p, default 5000, cycles between PHY reset release and MAC TX reset release.
REQ-003 SHALL have port clk_i  input  1  sole clock.
REQ-004 SHALL have port reset_i  input  1  synchronous active-high reset, driven by the upstream reset synchronizer output.
REQ-005 SHALL have port pll_locked_i  input  1  PLL lock, asynchronous to clk_i.
REQ-006 SHALL have port sw_reset_i  input  1  software restart request, synchronous to clk_i, level-sensitive.
REQ-007 SHALL have port phy_reset_n_o  output  1  active-low external PHY reset.
REQ-008 SHALL have port mac_tx_reset_o  output  1  active-high MAC TX-path reset.
REQ-009 SHALL have port mac_rx_reset_o  output  1  active-high MAC RX-path reset.
REQ-010 SHALL have port ready_o  output  1  high when all resets are released.
REQ-011 SHALL have port state_o  output  3  current FSM state, for debug.

Function
REQ-012 SHALL pass pll_locked_i through a 2-flop synchronizer; lock_s is the synchronized value, 2-cycle latency.
REQ-013 SHALL implement FSM states WAIT_LOCK, PHY_RST, SETTLE, TX_REL, RX_REL, READY.
REQ-014 SHALL drive outputs per state as (phy_reset_n, tx_rst, rx_rst, ready): WAIT_LOCK/PHY_RST=(0,1,1,0), SETTLE=(1,1,1,0), TX_REL=(1,0,1,0), RX_REL=(1,0,0,0), READY=(1,0,0,1).
REQ-015 SHALL drive all outputs directly from flops, changing on the same edge as the state register; no combinational output paths.
REQ-016 SHALL transition WAIT_LOCK->PHY_RST when lock_s=1, clearing the cycle counter.
REQ-017 SHALL hold PHY_RST for exactly phy_rst_cycles_p cycles, then enter SETTLE with the counter cleared.
REQ-018 SHALL hold SETTLE for exactly phy_settle_cycles_p cycles, then enter TX_REL.
REQ-019 SHALL hold TX_REL and RX_REL one cycle each, then enter READY and remain there.
REQ-020 SHALL, when lock_s=0 in any state other than WAIT_LOCK, enter WAIT_LOCK on the next edge (highest priority).
REQ-021 SHALL, when sw_reset_i=1 and lock_s=1 in any state, enter PHY_RST with the counter cleared; held sw_reset_i keeps PHY_RST re-armed.
REQ-022 SHALL size the counter as $clog2(max(phy_rst_cycles_p, phy_settle_cycles_p)+1) bits, with no wrap within a state.
REQ-023 SHALL fail elaboration if phy_rst_cycles_p<1 or phy_settle_cycles_p<1.

Reset
REQ-024 SHALL, while reset_i=1 at a clk_i edge, set state=WAIT_LOCK, counter=0, synchronizer flops=0, and outputs=(0,1,1,0).
REQ-025 SHALL, on reset_i mid-sequence (including READY), reassert all resets on that edge and restart from WAIT_LOCK.

Structure
REQ-026 SHALL take its state enum (3-bit) from shared package eth_reset_sequencer_pkg; state_o carries that encoding.
REQ-027 SHALL instantiate one sub-module, eth_sync2, a parameterizable-width 2-flop synchronizer with synchronous reset, for pll_locked_i.

Verification (phy_rst_cycles_p=4, phy_settle_cycles_p=3)
REQ-028 SHALL cover: lock=1 from start, reset_i released -> PHY_RST entered 3 cycles later (2 sync + 1); phy_reset_n_o low 4 cycles in PHY_RST then rises; tx_rst falls 3 cycles later; rx_rst falls 1 later; ready_o rises 1 later.
REQ-029 SHALL cover: lock deasserted 2 cycles into SETTLE -> state=WAIT_LOCK 3 cycles later, phy_reset_n_o=0, both MAC resets=1.
REQ-030 SHALL cover: sw_reset_i one-cycle pulse in READY -> next edge ready_o=0, phy_reset_n_o=0, full 4+3+1+1 sequence replays.
REQ-031 SHALL cover: sw_reset_i held 6 cycles from PHY_RST entry -> phy_reset_n_o low 6+4=10 cycles total.
REQ-032 SHALL cover: reset_i pulsed in TX_REL -> same edge outputs=(0,1,1,0), state_o=WAIT_LOCK.
REQ-033 SHALL cover: lock never asserted for 100 cycles -> state_o constant WAIT_LOCK, ready_o=0 throughout.
